// File: rtl/count_seq_checker_if.sv
// rtl/count_seq_checker_if.sv - sample stream and status bundle for count_seq_checker
interface count_seq_checker_if #(
  parameter int W   = 4,
  parameter int PW  = 5,
  parameter int WCW = 8
) ();
  logic           en;
  logic           clear;
  logic [W-1:0]   q_in;
  logic           z_in;
  logic [W-1:0]   lim_exp;
  logic           dir;
  logic           locked;
  logic [W-1:0]   limit;
  logic [PW-1:0]  period;
  logic           period_vld;
  logic [WCW-1:0] wrap_cnt;
  logic           err;
  logic [1:0]     err_code;

  modport master (
    output en, clear, q_in, z_in, lim_exp,
    input  dir, locked, limit, period, period_vld, wrap_cnt, err, err_code
  );

  modport slave (
    input  en, clear, q_in, z_in, lim_exp,
    output dir, locked, limit, period, period_vld, wrap_cnt, err, err_code
  );
endinterface

// File: rtl/count_seq_checker.sv
// rtl/count_seq_checker.sv - up/down limit counter stream monitor (direction, limit, wrap period, errors)
// Optional limit comparison against lim_exp enabled by defining CHK_LIMIT_EN.
module count_seq_checker #(
  parameter int W   = 4,
  parameter int PW  = 5,
  parameter int WCW = 8
) (
  input  logic                 clk,
  input  logic                 reset_p,
  count_seq_checker_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, SYNC, ARM, LOCK} state_t;

  state_t         r_state;
  logic [W-1:0]   r_prev;
  logic [PW-1:0]  r_cnt;
  logic           r_dir;
  logic           r_locked;
  logic [W-1:0]   r_limit;
  logic [PW-1:0]  r_period;
  logic           r_period_vld;
  logic [WCW-1:0] r_wrap_cnt;
  logic           r_err;
  logic [1:0]     r_err_code;

  logic [W-1:0]   w_prev_inc;
  logic [W-1:0]   w_prev_dec;
  logic           w_prev_max;
  logic           w_prev_zero;
  logic           w_q_zero;
  logic           w_step_ok;
  logic           w_wrap_ok;
  logic [W-1:0]   w_new_limit;
  logic [PW-1:0]  w_cnt_inc;

  assign w_prev_inc  = r_prev + 1'b1;
  assign w_prev_dec  = r_prev - 1'b1;
  assign w_prev_max  = &r_prev;
  assign w_prev_zero = (r_prev == '0);
  assign w_q_zero    = (bus.q_in == '0);
  // A locked step must not silently wrap; the counter only wraps together with z.
  assign w_step_ok   = r_dir ? ((bus.q_in == w_prev_inc) && !w_prev_max)
                             : ((bus.q_in == w_prev_dec) && !w_prev_zero);
  assign w_wrap_ok   = r_dir ? w_q_zero : w_prev_zero;
  assign w_new_limit = r_dir ? r_prev : bus.q_in;
  assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_state      <= IDLE;
      r_prev       <= '0;
      r_cnt        <= '0;
      r_dir        <= 1'b0;
      r_locked     <= 1'b0;
      r_limit      <= '0;
      r_period     <= '0;
      r_period_vld <= 1'b0;
      r_wrap_cnt   <= '0;
      r_err        <= 1'b0;
      r_err_code   <= 2'b00;
    end else if (bus.clear) begin
      r_state      <= IDLE;
      r_locked     <= 1'b0;
      r_period_vld <= 1'b0;
      r_wrap_cnt   <= '0;
      r_err        <= 1'b0;
      r_err_code   <= 2'b00;
    end else if (bus.en) begin
      r_prev       <= bus.q_in;
      r_period_vld <= 1'b0;
      case (r_state)
        IDLE: r_state <= SYNC;
        SYNC: begin
          if (!bus.z_in && (bus.q_in == w_prev_inc)) begin
            r_dir   <= 1'b1;
            r_state <= ARM;
          end else if (!bus.z_in && (bus.q_in == w_prev_dec) && !w_prev_zero) begin
            r_dir   <= 1'b0;
            r_state <= ARM;
          end else if (bus.z_in && w_q_zero && !w_prev_zero) begin
            r_dir    <= 1'b1;
            r_state  <= LOCK;
            r_locked <= 1'b1;
            r_cnt    <= PW'(1);
          end else if (bus.z_in && w_prev_zero && !w_q_zero) begin
            r_dir    <= 1'b0;
            r_state  <= LOCK;
            r_locked <= 1'b1;
            r_cnt    <= PW'(1);
          end
        end
        default: begin
          if (!bus.z_in) begin
            if (w_step_ok) begin
              r_cnt <= w_cnt_inc;
            end else begin
              r_state  <= SYNC;
              r_locked <= 1'b0;
              r_err    <= 1'b1;
              if (!r_err) r_err_code <= 2'b01;
            end
          end else if (!w_wrap_ok) begin
            r_state  <= SYNC;
            r_locked <= 1'b0;
            r_err    <= 1'b1;
            if (!r_err) r_err_code <= 2'b10;
          end else begin
            r_cnt    <= PW'(1);
            r_state  <= LOCK;
            r_locked <= 1'b1;
            // The carry that ends ARM only opens the first measurement window.
            if (r_state == LOCK) begin
              r_period     <= r_cnt;
              r_period_vld <= 1'b1;
              r_limit      <= w_new_limit;
              if (!(&r_wrap_cnt)) r_wrap_cnt <= r_wrap_cnt + 1'b1;
`ifdef CHK_LIMIT_EN
              if (w_new_limit != bus.lim_exp) begin
                r_err <= 1'b1;
                if (!r_err) r_err_code <= 2'b11;
              end
`endif
            end
          end
        end
      endcase
    end
  end

  assign bus.dir        = r_dir;
  assign bus.locked     = r_locked;
  assign bus.limit      = r_limit;
  assign bus.period     = r_period;
  assign bus.period_vld = r_period_vld;
  assign bus.wrap_cnt   = r_wrap_cnt;
  assign bus.err        = r_err;
  assign bus.err_code   = r_err_code;
endmodule

// File: tb/tb_count_seq_checker.sv
// tb/tb_count_seq_checker.sv - directed self-checking bench for count_seq_checker
module tb_count_seq_checker;
  logic clk = 1'b0;
  logic reset_p = 1'b1;
  int   errors = 0;
  int   checks = 0;

  count_seq_checker_if #(.W(4), .PW(5), .WCW(8)) bus ();

  count_seq_checker #(.W(4), .PW(5), .WCW(8)) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic smp(input logic [3:0] q, input logic z);
    bus.en = 1'b1; bus.q_in = q; bus.z_in = z;
    @(posedge clk); #1;
    bus.en = 1'b0;
  endtask

  task automatic gap();
    bus.en = 1'b0; bus.q_in = 4'($urandom_range(0, 15)); bus.z_in = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
  endtask

  task automatic up_run(input int a, input int b);
    for (int i = a; i <= b; i++) smp(4'(i), 1'b0);
  endtask

  task automatic down_run(input int a, input int b);
    for (int i = a; i >= b; i--) smp(4'(i), 1'b0);
  endtask

  task automatic do_reset();
    bus.en = 1'b0; bus.clear = 1'b0; bus.q_in = '0; bus.z_in = 1'b0; bus.lim_exp = '0;
    reset_p = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_p = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL rst_locked got %b exp 0", bus.locked); end
    checks++; if (bus.err !== 1'b0 || bus.err_code !== 2'b00) begin errors++; $display("FAIL rst_err got %b/%b exp 0/00", bus.err, bus.err_code); end
    checks++; if (bus.period !== 5'd0 || bus.limit !== 4'd0 || bus.wrap_cnt !== 8'd0 || bus.dir !== 1'b0 || bus.period_vld !== 1'b0)
      begin errors++; $display("FAIL rst_vals got p=%0d l=%0d w=%0d d=%b v=%b exp all 0", bus.period, bus.limit, bus.wrap_cnt, bus.dir, bus.period_vld); end
  endtask

  task automatic test_up_a5();
    do_reset();
    smp(4'd0, 1'b0); up_run(1, 5);
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL up_arm_locked got %b exp 0", bus.locked); end
    smp(4'd0, 1'b1);
    checks++; if (bus.locked !== 1'b1 || bus.dir !== 1'b1) begin errors++; $display("FAIL up_lock got l=%b d=%b exp 1/1", bus.locked, bus.dir); end
    checks++; if (bus.period_vld !== 1'b0 || bus.wrap_cnt !== 8'd0) begin errors++; $display("FAIL up_first_carry got v=%b w=%0d exp 0/0", bus.period_vld, bus.wrap_cnt); end
    for (int k = 1; k <= 2; k++) begin
      up_run(1, 5); smp(4'd0, 1'b1);
      checks++; if (bus.period !== 5'd6 || bus.limit !== 4'd5 || bus.period_vld !== 1'b1)
        begin errors++; $display("FAIL up_wrap%0d got p=%0d l=%0d v=%b exp 6/5/1", k, bus.period, bus.limit, bus.period_vld); end
      checks++; if (bus.wrap_cnt !== 8'(k) || bus.err !== 1'b0 || bus.dir !== 1'b1)
        begin errors++; $display("FAIL up_wrap%0d_status got w=%0d e=%b d=%b exp %0d/0/1", k, bus.wrap_cnt, bus.err, bus.dir, k); end
    end
    smp(4'd1, 1'b0);
    checks++; if (bus.period_vld !== 1'b0) begin errors++; $display("FAIL up_vld_pulse got %b exp 0", bus.period_vld); end
  endtask

  task automatic test_down_b9();
    do_reset();
    smp(4'd9, 1'b0); down_run(8, 0); smp(4'd9, 1'b1);
    checks++; if (bus.locked !== 1'b1 || bus.dir !== 1'b0) begin errors++; $display("FAIL dn_lock got l=%b d=%b exp 1/0", bus.locked, bus.dir); end
    for (int k = 1; k <= 3; k++) begin
      down_run(8, 0); smp(4'd9, 1'b1);
      checks++; if (bus.period !== 5'd10 || bus.limit !== 4'd9 || bus.wrap_cnt !== 8'(k) || bus.dir !== 1'b0)
        begin errors++; $display("FAIL dn_wrap%0d got p=%0d l=%0d w=%0d d=%b exp 10/9/%0d/0", k, bus.period, bus.limit, bus.wrap_cnt, bus.dir, k); end
    end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL dn_err got %b exp 0", bus.err); end
  endtask

  task automatic test_en_toggle();
    do_reset();
    for (int i = 0; i <= 15; i++) begin smp(4'(i), 1'b0); gap(); end
    smp(4'd0, 1'b1); gap();
    checks++; if (bus.locked !== 1'b1 || bus.err !== 1'b0) begin errors++; $display("FAIL tog_lock got l=%b e=%b exp 1/0", bus.locked, bus.err); end
    for (int i = 1; i <= 15; i++) begin smp(4'(i), 1'b0); gap(); end
    smp(4'd0, 1'b1);
    checks++; if (bus.period !== 5'd16 || bus.limit !== 4'd15 || bus.period_vld !== 1'b1)
      begin errors++; $display("FAIL tog_wrap got p=%0d l=%0d v=%b exp 16/15/1", bus.period, bus.limit, bus.period_vld); end
    gap(); gap();
    checks++; if (bus.period !== 5'd16 || bus.wrap_cnt !== 8'd1 || bus.locked !== 1'b1 || bus.err !== 1'b0)
      begin errors++; $display("FAIL tog_hold got p=%0d w=%0d l=%b e=%b exp 16/1/1/0", bus.period, bus.wrap_cnt, bus.locked, bus.err); end
  endtask

  task automatic test_step_error();
    do_reset();
    smp(4'd0, 1'b0); up_run(1, 5); smp(4'd0, 1'b1); up_run(1, 3);
    smp(4'd7, 1'b0);
    checks++; if (bus.err !== 1'b1 || bus.err_code !== 2'b01 || bus.locked !== 1'b0)
      begin errors++; $display("FAIL step_err got e=%b c=%b l=%b exp 1/01/0", bus.err, bus.err_code, bus.locked); end
    smp(4'd4, 1'b0); smp(4'd5, 1'b0);
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL step_arm got l=%b exp 0", bus.locked); end
    smp(4'd0, 1'b1);
    checks++; if (bus.locked !== 1'b1 || bus.err_code !== 2'b01) begin errors++; $display("FAIL step_relock got l=%b c=%b exp 1/01", bus.locked, bus.err_code); end
    up_run(1, 3); smp(4'd3, 1'b1);
    checks++; if (bus.locked !== 1'b0 || bus.err !== 1'b1 || bus.err_code !== 2'b01)
      begin errors++; $display("FAIL step_sticky got l=%b e=%b c=%b exp 0/1/01", bus.locked, bus.err, bus.err_code); end
  endtask

  task automatic test_clear();
    bus.clear = 1'b1; smp(4'd4, 1'b0); bus.clear = 1'b0;
    checks++; if (bus.err !== 1'b0 || bus.err_code !== 2'b00 || bus.wrap_cnt !== 8'd0 || bus.locked !== 1'b0)
      begin errors++; $display("FAIL clr got e=%b c=%b w=%0d l=%b exp 0/00/0/0", bus.err, bus.err_code, bus.wrap_cnt, bus.locked); end
    smp(4'd0, 1'b0); smp(4'd1, 1'b0); smp(4'd2, 1'b0); smp(4'd5, 1'b1);
    checks++; if (bus.err !== 1'b1 || bus.err_code !== 2'b10 || bus.locked !== 1'b0)
      begin errors++; $display("FAIL badwrap got e=%b c=%b l=%b exp 1/10/0", bus.err, bus.err_code, bus.locked); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    smp(4'd0, 1'b0); up_run(1, 5); smp(4'd0, 1'b1); up_run(1, 5); smp(4'd0, 1'b1); up_run(1, 2);
    #3 reset_p = 1'b1;
    #1;
    checks++; if (bus.locked !== 1'b0 || bus.period !== 5'd0 || bus.limit !== 4'd0 || bus.wrap_cnt !== 8'd0 || bus.dir !== 1'b0)
      begin errors++; $display("FAIL async_rst got l=%b p=%0d li=%0d w=%0d d=%b exp all 0", bus.locked, bus.period, bus.limit, bus.wrap_cnt, bus.dir); end
    @(posedge clk); #1 reset_p = 1'b0;
    smp(4'd3, 1'b0); up_run(4, 5); smp(4'd0, 1'b1); up_run(1, 5); smp(4'd0, 1'b1);
    checks++; if (bus.locked !== 1'b1 || bus.period !== 5'd6 || bus.wrap_cnt !== 8'd1 || bus.err !== 1'b0)
      begin errors++; $display("FAIL rst_relock got l=%b p=%0d w=%0d e=%b exp 1/6/1/0", bus.locked, bus.period, bus.wrap_cnt, bus.err); end
  endtask

  task automatic test_limit();
    do_reset();
    bus.lim_exp = 4'd7;
    smp(4'd0, 1'b0); up_run(1, 5); smp(4'd0, 1'b1); up_run(1, 5); smp(4'd0, 1'b1);
`ifdef CHK_LIMIT_EN
    checks++; if (bus.err !== 1'b1 || bus.err_code !== 2'b11 || bus.locked !== 1'b1 || bus.period !== 5'd6)
      begin errors++; $display("FAIL lim_chk got e=%b c=%b l=%b p=%0d exp 1/11/1/6", bus.err, bus.err_code, bus.locked, bus.period); end
`else
    checks++; if (bus.err !== 1'b0 || bus.err_code !== 2'b00 || bus.locked !== 1'b1 || bus.period !== 5'd6)
      begin errors++; $display("FAIL lim_off got e=%b c=%b l=%b p=%0d exp 0/00/1/6", bus.err, bus.err_code, bus.locked, bus.period); end
`endif
  endtask

  initial begin
    test_reset();
    test_up_a5();
    test_down_b9();
    test_en_toggle();
    test_step_error();
    test_clear();
    test_reset_mid();
    test_limit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
